// File: rtl/scaled_normalizer.sv
// Converts a wide signed fixed-point value into the packed {scale[2:0], mantissa[12:0]}
// format. The block searches for the largest scale that fits by shifting right one bit per cycle.
module scaled_normalizer #(
    parameter int IN_W    = 24,
    parameter int IN_FRAC = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data,
    output logic            invalid
);

    localparam int SHIFT = IN_FRAC - 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [IN_W-1:0]   x_r, x_s;
    logic [2:0]        scale_r, scale_s;
    logic [15:0]       out_data_r, out_data_s;
    logic              invalid_r, invalid_s;
    logic              out_valid_r, out_valid_s;
    logic [IN_W-1:0]   load_s;

    // The value fits when every bit from the mantissa sign bit upward is a copy of the sign.
    function automatic logic fits_f(input logic [IN_W-1:0] v);
        logic [IN_W-13:0] hi;
        hi = v[IN_W-1:12];
        return (&hi) | ~(|hi);
    endfunction

    assign load_s    = $signed(in_data) >>> SHIFT;
    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign invalid   = invalid_r;

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            x_r         <= '0;
            scale_r     <= 3'd0;
            out_data_r  <= 16'h0000;
            invalid_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            scale_r     <= scale_s;
            out_data_r  <= out_data_s;
            invalid_r   <= invalid_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Next-state and next-datapath logic for the accept / scan / hold sequence.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        scale_s     = scale_r;
        out_data_s  = out_data_r;
        invalid_s   = invalid_r;
        out_valid_s = out_valid_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    x_s     = load_s;
                    scale_s = 3'd7;
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (fits_f(x_r)) begin
                    out_data_s  = {scale_r, x_r[12:0]};
                    invalid_s   = 1'b0;
                    out_valid_s = 1'b1;
                    state_s     = DONE;
                end else if (scale_r == 3'd0) begin
                    // Out of range even with no fractional bits: clamp to the mantissa limits.
                    out_data_s  = x_r[IN_W-1] ? 16'h1000 : 16'h0FFF;
                    invalid_s   = 1'b1;
                    out_valid_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    x_s     = {x_r[IN_W-1], x_r[IN_W-1:1]};
                    scale_s = scale_r - 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_scaled_normalizer.sv
// Self-checking bench for scaled_normalizer: directed plan cases plus randomized values
// checked against an arithmetic reference of the scale search.
module tb_scaled_normalizer;

    localparam int IN_W    = 24;
    localparam int IN_FRAC = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_data;
    logic            invalid;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_data;
    logic        exp_inv;
    int          exp_lat;

    scaled_normalizer #(.IN_W(IN_W), .IN_FRAC(IN_FRAC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: value at scale s is floor(x0 / 2^(7-s)); pick the largest s in range.
    task automatic model(input logic [IN_W-1:0] d);
        logic signed [IN_W-1:0] ds;
        longint x0, xs;
        bit found;
        ds = d;
        x0 = longint'(ds) >>> (IN_FRAC - 7);
        found = 0;
        for (int s = 7; s >= 0; s--) begin
            xs = x0 >>> (7 - s);
            if (!found && xs >= -4096 && xs <= 4095) begin
                found    = 1;
                exp_data = {3'(s), 13'(xs)};
                exp_inv  = 1'b0;
                exp_lat  = 1 + (7 - s);
            end
        end
        if (!found) begin
            exp_data = (x0 < 0) ? 16'h1000 : 16'h0FFF;
            exp_inv  = 1'b1;
            exp_lat  = 8;
        end
    endtask

    task automatic start_and_wait(input string tag, input logic [IN_W-1:0] d);
        int lat;
        bit seen;
        model(d);
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            lat++;
            if (out_valid) seen = 1;
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_out_data"}, 32'(out_data), 32'(exp_data));
        chk({tag, "_invalid"}, 32'(invalid), 32'(exp_inv));
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic txn(input string tag, input logic [IN_W-1:0] d);
        start_and_wait(tag, d);
        release_out(tag);
    endtask

    initial begin
        logic [IN_W-1:0] r;
        int nb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0000);
        chk("rst_invalid", 32'(invalid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed plan values with hand-derived expectations.
        txn("fit_192", 24'd192);
        chk("fit_192_hand", 32'(exp_data), 32'hE0C0);
        txn("trunc_m1", -24'sd1);
        chk("trunc_m1_hand", 32'(exp_data), 32'hFFFF);
        txn("pos_shift", 24'd12800);
        chk("pos_shift_hand", 32'(exp_data), 32'hAC80);
        txn("neg_shift", -24'sd12800);
        chk("neg_shift_hand", 32'(exp_data), 32'hB380);
        txn("ovf_pos", 24'd640000);
        chk("ovf_pos_hand", 32'(exp_data), 32'h0FFF);
        txn("ovf_neg", -24'sd640000);
        chk("ovf_neg_hand", 32'(exp_data), 32'h1000);
        txn("zero", 24'd0);
        chk("zero_hand", 32'(exp_data), 32'hE000);
        txn("max_pos", 24'h7FFFFF);
        txn("max_neg", 24'h800000);

        // Backpressure: output held, new inputs ignored.
        start_and_wait("bp", 24'd12800);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 24'($urandom);
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'hAC80);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out("bp");
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_accept_valid", 32'(out_valid), 32'd0);
        chk("bp_no_accept_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of a scan.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 24'd640000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'h0000);
        chk("mid_rst_invalid", 32'(invalid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        txn("post_rst_192", 24'd192);
        chk("post_rst_192_hand", 32'(exp_data), 32'hE0C0);

        // Randomized magnitudes across the full input range.
        for (int i = 0; i < 40; i++) begin
            nb = $urandom_range(IN_W - 1, 0);
            r  = 24'($urandom) & ((24'd1 << nb) - 24'd1);
            if ($urandom_range(1, 0) == 1) r = -r;
            txn("rand", r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scaled_normalizer.md
Name: scaled_normalizer

Overview:
- Converts a wide signed fixed-point value into the packed 16-bit scaled format that the adder/subtractor and the other ODE datapath blocks consume.
- The packed format is {scale[2:0], mantissa[12:0]}. Value = signed(mantissa) * 2^-scale.
- The block runs the inverse of operand alignment. It picks the largest scale (most fractional precision) whose mantissa fits in 13 signed bits.
- It sits after multiply/accumulate stages, uses a valid/ready handshake on both sides, and searches iteratively with one right shift per cycle.

Parameters:
- IN_W, 24, width of the signed input in_data. Legal range 14..32.
- IN_FRAC, 7, number of fractional bits in in_data. Legal range 7..IN_W-2.

Ports:
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a value; equals (state==IDLE).
- in_data  input  IN_W  signed fixed-point value with IN_FRAC fractional bits.
- out_valid  output  1  out_data and invalid are valid.
- out_ready  input  1  downstream accepts the output.
- out_data  output  16  packed result {scale[2:0], mantissa[12:0]}.
- invalid  output  1  the value did not fit even at scale 0; out_data is saturated.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, out_valid=0, out_data=16'h0000, invalid=0.
  - Internal shift register and scale counter cleared.
  - in_ready=1 while in reset and after it.
  - Reset asserted mid-operation aborts the operation. No output is produced for the aborted value.
- States: IDLE, SCAN, DONE.
- IDLE, on in_valid && in_ready at a rising edge:
  - Load x = in_data >>> (IN_FRAC-7), arithmetic shift, sign kept, width IN_W.
  - Set s=7 and go to SCAN.
- SCAN, per cycle:
  - fits = (x[IN_W-1:12] all ones or all zeros).
  - If fits: out_data={s, x[12:0]}, invalid=0, go to DONE.
  - Else if s==0: saturate. out_data={3'b000, 13'h0FFF} if x is positive, {3'b000, 13'h1000} if negative. invalid=1. Go to DONE.
  - Else: x = x >>> 1, s = s-1, stay in SCAN.
- Rounding: truncation toward minus infinity (arithmetic right shift). No round-to-nearest.
- Latency: out_valid rises 1+k edges after the accepting edge, where k = number of shifts (0..7). Maximum is 8.
- DONE:
  - out_valid=1. out_data and invalid are held stable until out_ready.
  - On out_valid && out_ready, return to IDLE. out_valid=0 on the next cycle and in_ready=1 on the next cycle.
- in_ready=0 in SCAN and DONE. in_valid is ignored in those states; there is no queueing.
- Zero input: fits immediately. out_data=16'hE000 (scale 7, mantissa 0), latency 1.
- out_data and invalid keep their last values in IDLE. Consumers qualify them with out_valid only.

Test Plan:
- Fits immediately: IN_FRAC=7, in_data=192 (1.5). Expect out_data=16'hE0C0, invalid=0, out_valid one edge after accept.
- Truncation: in_data=-1 (-1/128). Expect 16'hFFFF, latency 1.
- Positive shift: in_data=12800 (100.0). Two shifts to 3200 at s=5. Expect 16'hAC80, latency 3.
- Negative shift: in_data=-12800 (-100.0). Expect 16'hB380, latency 3.
- Overflow, positive: in_data=640000 (5000.0). Expect 16'h0FFF, invalid=1, latency 8.
- Overflow, negative: in_data=-640000. Expect 16'h1000, invalid=1, latency 8.
- Backpressure: after a result, hold out_ready=0 for 5 cycles while pulsing in_valid with new data. Expect out_data stable, in_ready=0 and the new data not accepted. Raise out_ready: out_valid drops next cycle and in_ready=1.
- Reset mid-SCAN: accept 640000, pull rst_n low asynchronously 3 cycles later. Expect out_valid=0, out_data=0, invalid=0, in_ready=1 immediately. A following input of 192 yields 16'hE0C0.
